// File: rtl/clk_gate_pkg.sv
// Shared state encoding and counter sizing for the clock-gate controller.
package clk_gate_pkg;
  typedef enum logic [1:0] {
    OFF  = 2'd0,
    WAKE = 2'd1,
    ON   = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam int WAKE_MAX = 15;
  localparam int IDLE_MAX = 255;
  localparam int WAKE_W   = $clog2(WAKE_MAX + 1);
  localparam int IDLE_W   = $clog2(IDLE_MAX + 1);
  localparam int STAT_W   = 16;
endpackage

// File: rtl/clk_gate_timer.sv
// Loadable down-counter that saturates at zero; flags zero and the final tick.
module clk_gate_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero,
  output logic         last
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                   cnt <= '0;
    else if (load)             cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
  assign last = (cnt == W'(1));
endmodule

// File: rtl/clk_gate_ctrl.sv
// Clock-gate enable controller: OFF/WAKE/ON/HOLD with idle timeout and wake settle.
// Define CLK_GATE_STATS_EN to add the saturating GATED_CYCLES counter.
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int IDLE_CYCLES = 8,
  parameter int WAKE_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ,
  input  logic              BUSY,
  output logic              CLK_EN,
  output logic              ACK
`ifdef CLK_GATE_STATS_EN
  ,
  output logic [STAT_W-1:0] GATED_CYCLES
`endif
);
  state_t state, state_d;
  logic   idle;
  logic   wake_load, wake_dec, wake_zero, wake_last;
  logic   idle_load, idle_dec, idle_zero, idle_last;

  assign idle = !REQ && !BUSY;

  clk_gate_timer #(.W(WAKE_W)) u_wake (
    .clk(CLK), .rst(RST), .load(wake_load), .load_val(WAKE_W'(WAKE_CYCLES)),
    .dec(wake_dec), .zero(wake_zero), .last(wake_last)
  );

  clk_gate_timer #(.W(IDLE_W)) u_idle (
    .clk(CLK), .rst(RST), .load(idle_load), .load_val(IDLE_W'(IDLE_CYCLES)),
    .dec(idle_dec), .zero(idle_zero), .last(idle_last)
  );

  // A zero count in WAKE/HOLD cannot occur after a legal load; treating it as
  // expiry keeps the FSM from parking there forever.
  always_comb begin
    state_d   = state;
    wake_load = 1'b0;
    wake_dec  = 1'b0;
    idle_load = 1'b0;
    idle_dec  = 1'b0;
    case (state)
      OFF: if (REQ) begin
        state_d   = WAKE;
        wake_load = 1'b1;
      end
      WAKE: begin
        wake_dec = 1'b1;
        if (wake_last || wake_zero) state_d = ON;
      end
      ON: if (idle) begin
        state_d   = HOLD;
        idle_load = 1'b1;
      end
      HOLD: begin
        if (!idle) state_d = ON;
        else begin
          idle_dec = 1'b1;
          if (idle_last || idle_zero) state_d = OFF;
        end
      end
      default: state_d = OFF;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register and drive the gate cell straight from a flop.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= OFF;
      CLK_EN <= 1'b0;
      ACK    <= 1'b0;
    end else begin
      state  <= state_d;
      CLK_EN <= (state_d != OFF);
      ACK    <= (state_d == ON) || (state_d == HOLD);
    end
  end

`ifdef CLK_GATE_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST)                           GATED_CYCLES <= '0;
    else if (!CLK_EN && GATED_CYCLES != '1) GATED_CYCLES <= GATED_CYCLES + 1'b1;
  end
`endif
endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Scoreboard bench for clk_gate_ctrl: expected CLK_EN/ACK/state queued per edge.
module tb_clk_gate_ctrl;
  import clk_gate_pkg::*;

  logic CLK, RST, REQ, BUSY, CLK_EN, ACK;
`ifdef CLK_GATE_STATS_EN
  logic [STAT_W-1:0] GATED_CYCLES;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    string  tag;
    logic   en;
    logic   ack;
    state_t st;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  clk_gate_ctrl #(.IDLE_CYCLES(8), .WAKE_CYCLES(2)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .BUSY(BUSY), .CLK_EN(CLK_EN), .ACK(ACK)
`ifdef CLK_GATE_STATS_EN
    , .GATED_CYCLES(GATED_CYCLES)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Drive one edge's inputs and queue what the outputs must be after that edge.
  task automatic step(input logic rst, input logic req, input logic busy,
                      input logic en, input logic ack, input state_t st, input string tag);
    @(negedge CLK);
    RST = rst; REQ = req; BUSY = busy;
    sb.push_back('{tag, en, ack, st});
  endtask

  always @(posedge CLK) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk({mon_e.tag, ".en"},  32'(CLK_EN),    32'(mon_e.en));
      chk({mon_e.tag, ".ack"}, 32'(ACK),       32'(mon_e.ack));
      chk({mon_e.tag, ".st"},  32'(dut.state), 32'(mon_e.st));
    end
  end

  initial begin
    RST = 1'b1; REQ = 1'b0; BUSY = 1'b0;
    // cold wake
    step(1,0,0, 0,0,OFF,  "rst0");
    step(1,0,0, 0,0,OFF,  "rst1");
    step(0,0,0, 0,0,OFF,  "off");
    step(0,1,0, 1,0,WAKE, "wake_a");
    step(0,0,0, 1,0,WAKE, "wake_b");
    step(0,0,0, 1,1,ON,   "on");
    repeat (4) step(0,1,0, 1,1,ON, "on_req");
    // idle gating: 8 HOLD edges then OFF
    step(0,0,0, 1,1,HOLD, "hold_enter");
    repeat (7) step(0,0,0, 1,1,HOLD, "hold");
    step(0,0,0, 0,0,OFF,  "gated");
    // BUSY alone never wakes, nor affects WAKE
    repeat (2) step(0,0,1, 0,0,OFF, "busy_off");
    step(0,1,0, 1,0,WAKE, "wake2_a");
    step(0,0,1, 1,0,WAKE, "wake2_busy");
    step(0,0,0, 1,1,ON,   "on2");
    // re-arm restarts the full idle count
    step(0,0,0, 1,1,HOLD, "rearm_hold");
    repeat (2) step(0,0,0, 1,1,HOLD, "rearm_hold_n");
    step(0,0,1, 1,1,ON,   "rearm_busy");
    step(0,0,0, 1,1,HOLD, "rearm_hold2");
    repeat (7) step(0,0,0, 1,1,HOLD, "rearm_hold2_n");
    step(0,0,0, 0,0,OFF,  "rearm_gated");
    // expiry race: REQ on the final HOLD edge wins
    step(0,1,0, 1,0,WAKE, "wake3_a");
    step(0,1,0, 1,0,WAKE, "wake3_req");
    step(0,1,0, 1,1,ON,   "on3");
    step(0,0,0, 1,1,HOLD, "race_hold");
    repeat (7) step(0,0,0, 1,1,HOLD, "race_hold_n");
    step(0,1,0, 1,1,ON,   "race");
    step(0,1,0, 1,1,ON,   "race_stay");
    // reset during HOLD
    step(0,0,0, 1,1,HOLD, "pre_rst_hold");
    step(1,0,0, 0,0,OFF,  "rst_hold");
    // reset during WAKE, then REQ right after release takes the normal path
    step(0,1,0, 1,0,WAKE, "pre_rst_wake");
    step(1,1,0, 0,0,OFF,  "rst_wake");
    step(0,1,0, 1,0,WAKE, "post_rst_a");
    step(0,0,0, 1,0,WAKE, "post_rst_b");
    step(0,0,0, 1,1,ON,   "post_rst_on");
`ifdef CLK_GATE_STATS_EN
    step(1,0,0, 0,0,OFF,  "st_rst");
    repeat (5) step(0,0,0, 0,0,OFF, "st_off");
    @(negedge CLK);
    chk("gated_5", 32'(GATED_CYCLES), 32'd5);
    repeat (70000) @(negedge CLK);
    chk("gated_sat", 32'(GATED_CYCLES), 32'hFFFF);
    step(1,0,0, 0,0,OFF,  "st_clr");
    @(negedge CLK);
    chk("gated_clr", 32'(GATED_CYCLES), 32'd0);
`endif
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge CLK);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
